// File: rtl/pipelined_ks_adder.sv
// Pipelined Kogge-Stone adder/subtractor.
//
// One operand pair enters per cycle. Stage 0 forms the per-bit propagate and
// generate terms and folds in the carry-in. Stages 1..LEVELS each register one
// prefix level. A final output stage registers the sum, the carry out and the
// signed overflow. Valid/ready flow control stalls every stage together.
//
// Parameters
//   WIDTH     operand width, a power of two from 4 to 64
// Ports
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   a, b      operands
//   cin       carry-in (ignored when sub=1)
//   sub       0: a+b+cin, 1: a-b
//   in_valid  operand qualifier
//   in_ready  pipeline can accept this cycle
//   sum       registered result, low WIDTH bits
//   cout      carry out of bit WIDTH-1
//   ovf       signed overflow
//   out_valid result qualifier
//   out_ready downstream accepts the result
module pipelined_ks_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned LEVELS = $clog2(WIDTH);

  logic adv;

  // Stage 0 combinational terms
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [WIDTH-1:0] p0;
  logic [WIDTH-1:0] g0;

  // Pipeline registers, index = stage number
  logic [WIDTH-1:0] p_q  [0:LEVELS];   // original propagate, unmodified
  logic [WIDTH-1:0] gg_q [0:LEVELS];   // prefix generate
  logic [WIDTH-1:0] gp_q [0:LEVELS-1]; // prefix propagate
  logic             cin_q [0:LEVELS];
  logic             vld_q [0:LEVELS];

  // Next-level prefix values, index = level number
  logic [WIDTH-1:0] g_nxt  [1:LEVELS];
  logic [WIDTH-1:0] pr_nxt [1:LEVELS-1];

  // Output stage combinational terms
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] carry_in;
  logic [WIDTH-1:0] sum_d;
  logic             ovf_d;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    b_eff   = sub ? ~b : b;
    cin_eff = sub | cin;
    p0      = a ^ b_eff;
    g0      = a & b_eff;
    // Folding the carry-in into bit 0 makes the final G[i] the true carry out of bit i.
    g0[0]   = g0[0] | (p0[0] & cin_eff);
  end

  for (genvar l = 1; l <= LEVELS; l++) begin : g_level
    localparam int D = 1 << (l - 1);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= D) begin : g_op
        assign g_nxt[l][i] = gg_q[l-1][i] | (gp_q[l-1][i] & gg_q[l-1][i-D]);
        // The last level's group propagate feeds nothing, so it is not kept.
        if (l < LEVELS) begin : g_p
          assign pr_nxt[l][i] = gp_q[l-1][i] & gp_q[l-1][i-D];
        end
      end else begin : g_pass
        assign g_nxt[l][i] = gg_q[l-1][i];
        if (l < LEVELS) begin : g_p
          assign pr_nxt[l][i] = gp_q[l-1][i];
        end
      end
    end
  end

  always_comb begin
    carry    = gg_q[LEVELS];
    carry_in = {carry[WIDTH-2:0], cin_q[LEVELS]};
    sum_d    = p_q[LEVELS] ^ carry_in;
    ovf_d    = carry[WIDTH-2] ^ carry[WIDTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s <= LEVELS; s++) begin
        p_q[s]   <= '0;
        gg_q[s]  <= '0;
        cin_q[s] <= 1'b0;
        vld_q[s] <= 1'b0;
      end
      for (int unsigned s = 0; s < LEVELS; s++) begin
        gp_q[s] <= '0;
      end
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      p_q[0]   <= p0;
      gp_q[0]  <= p0;
      gg_q[0]  <= g0;
      cin_q[0] <= cin_eff;
      vld_q[0] <= in_valid;
      for (int unsigned s = 1; s <= LEVELS; s++) begin
        p_q[s]   <= p_q[s-1];
        gg_q[s]  <= g_nxt[s];
        cin_q[s] <= cin_q[s-1];
        vld_q[s] <= vld_q[s-1];
      end
      for (int unsigned s = 1; s < LEVELS; s++) begin
        gp_q[s] <= pr_nxt[s];
      end
      sum       <= sum_d;
      cout      <= carry[WIDTH-1];
      ovf       <= ovf_d;
      out_valid <= vld_q[LEVELS];
    end
  end

endmodule

// File: tb/tb_pipelined_ks_adder.sv
module tb_pipelined_ks_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // WIDTH=16 instance
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic cin16 = 0, sub16 = 0, in_valid16 = 0, in_ready16, cout16, ovf16, out_valid16;
  logic out_ready16 = 1;

  // WIDTH=4 instance
  logic [3:0] a4 = '0, b4 = '0, sum4;
  logic cin4 = 0, sub4 = 0, in_valid4 = 0, in_ready4, cout4, ovf4, out_valid4;
  logic out_ready4 = 1;

  // WIDTH=64 instance
  logic [63:0] a64 = '0, b64 = '0, sum64;
  logic cin64 = 0, sub64 = 0, in_valid64 = 0, in_ready64, cout64, ovf64, out_valid64;
  logic out_ready64 = 1;

  pipelined_ks_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin16), .sub(sub16),
    .in_valid(in_valid16), .in_ready(in_ready16), .sum(sum16), .cout(cout16),
    .ovf(ovf16), .out_valid(out_valid16), .out_ready(out_ready16)
  );

  pipelined_ks_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .in_valid(in_valid4), .in_ready(in_ready4), .sum(sum4), .cout(cout4),
    .ovf(ovf4), .out_valid(out_valid4), .out_ready(out_ready4)
  );

  pipelined_ks_adder #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .a(a64), .b(b64), .cin(cin64), .sub(sub64),
    .in_valid(in_valid64), .in_ready(in_ready64), .sum(sum64), .cout(cout64),
    .ovf(ovf64), .out_valid(out_valid64), .out_ready(out_ready64)
  );

  // Reference: plain wide addition; result packed as {ovf, cout, sum[63:0]}.
  function automatic logic [65:0] model(input int unsigned w, input logic [63:0] ia, ib,
                                        input logic icin, isub);
    logic [64:0] mask, aa, bb, t;
    logic        co, ov;
    mask = (65'd1 << w) - 65'd1;
    aa   = {1'b0, ia} & mask;
    bb   = (isub ? ~{1'b0, ib} : {1'b0, ib}) & mask;
    t    = aa + bb + {64'd0, (isub | icin)};
    co   = t[w];
    ov   = (aa[w-1] == bb[w-1]) && (t[w-1] != aa[w-1]);
    return {ov, co, t[63:0] & mask[63:0]};
  endfunction

  // Drives one operand into dut16 and waits (bounded) for its result.
  task automatic run_op(input logic [15:0] ia, ib, input logic icin, isub,
                        output logic [15:0] s, output logic co, ov, output int lat);
    a16 = ia; b16 = ib; cin16 = icin; sub16 = isub; in_valid16 = 1;
    lat = 0;
    @(posedge clk); lat = 1;
    @(negedge clk); in_valid16 = 0;
    while (!out_valid16 && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    s = sum16; co = cout16; ov = ovf16;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (out_valid16 !== 1'b0) begin bad++; $display("FAIL reset_out_valid16: got %b want 0", out_valid16); end
    total++; if (sum16 !== 16'h0) begin bad++; $display("FAIL reset_sum16: got %h want 0000", sum16); end
    total++; if ({cout16, ovf16} !== 2'b00) begin bad++; $display("FAIL reset_cout_ovf16: got %b want 00", {cout16, ovf16}); end
    total++; if ({out_valid4, out_valid64} !== 2'b00) begin bad++; $display("FAIL reset_out_valid_4_64: got %b want 00", {out_valid4, out_valid64}); end
    rst = 0;
    #1;
    total++; if (in_ready16 !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready16); end
  endtask

  task automatic test_latency();
    logic [15:0] s; logic co, ov; int lat;
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, co, ov, lat);
    total++; if (lat != 6) begin bad++; $display("FAIL latency: got %0d edges want 6", lat); end
    total++; if ({s, co, ov} !== {16'h0000, 1'b1, 1'b0}) begin bad++; $display("FAIL wrap_ffff_1: got sum=%h cout=%b ovf=%b want 0000 1 0", s, co, ov); end
  endtask

  task automatic test_overflow();
    logic [15:0] s; logic co, ov; int lat;
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, co, ov, lat);
    total++; if ({s, co, ov} !== {16'h8000, 1'b0, 1'b1} || lat != 6) begin bad++; $display("FAIL add_ovf: got sum=%h cout=%b ovf=%b lat=%0d want 8000 0 1 6", s, co, ov, lat); end
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, s, co, ov, lat);
    total++; if ({s, co, ov} !== {16'h7FFF, 1'b1, 1'b1} || lat != 6) begin bad++; $display("FAIL sub_ovf: got sum=%h cout=%b ovf=%b lat=%0d want 7fff 1 1 6", s, co, ov, lat); end
    run_op(16'h1234, 16'h4321, 1'b1, 1'b0, s, co, ov, lat);
    total++; if ({s, co, ov} !== {16'h5556, 1'b0, 1'b0} || lat != 6) begin bad++; $display("FAIL add_cin: got sum=%h cout=%b ovf=%b lat=%0d want 5556 0 0 6", s, co, ov, lat); end
  endtask

  task automatic test_sub_cin();
    logic [15:0] s; logic co, ov; int lat;
    run_op(16'h1234, 16'h1234, 1'b1, 1'b1, s, co, ov, lat);
    total++; if ({s, co, ov} !== {16'h0000, 1'b1, 1'b0} || lat != 6) begin bad++; $display("FAIL sub_cin_ignored: got sum=%h cout=%b ovf=%b lat=%0d want 0000 1 0 6", s, co, ov, lat); end
    run_op(16'h0003, 16'h0005, 1'b0, 1'b1, s, co, ov, lat);
    total++; if ({s, co, ov} !== {16'hFFFE, 1'b0, 1'b0} || lat != 6) begin bad++; $display("FAIL sub_borrow: got sum=%h cout=%b ovf=%b lat=%0d want fffe 0 0 6", s, co, ov, lat); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [20], vb [20];
    logic        vc [20], vs [20];
    logic [65:0] q [$];
    logic [65:0] e;
    int sent = 0, got = 0;
    for (int i = 0; i < 20; i++) begin
      va[i] = 16'($urandom); vb[i] = 16'($urandom);
      vc[i] = 1'($urandom); vs[i] = 1'($urandom);
    end
    for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
      out_ready16 = !(cyc >= 10 && cyc < 13);
      in_valid16  = (sent < 20);
      if (sent < 20) begin
        a16 = va[sent]; b16 = vb[sent]; cin16 = vc[sent]; sub16 = vs[sent];
      end
      #1;
      if (!out_ready16) begin
        total++; if (in_ready16 !== 1'b0) begin bad++; $display("FAIL stall_in_ready: got %b want 0 (cyc %0d)", in_ready16, cyc); end
        total++;
        if (!out_valid16 || q.size() == 0 || {ovf16, cout16, sum16} !== {q[0][65:64], q[0][15:0]}) begin
          bad++; $display("FAIL stall_hold: got v=%b sum=%h cout=%b ovf=%b (cyc %0d)", out_valid16, sum16, cout16, ovf16, cyc);
        end
      end
      if (out_valid16 && out_ready16) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL stream_extra: got unexpected result %h want none", sum16);
        end else begin
          e = q.pop_front();
          if ({ovf16, cout16, sum16} !== {e[65:64], e[15:0]}) begin
            bad++; $display("FAIL stream_result_%0d: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                            got, sum16, cout16, ovf16, e[15:0], e[64], e[65]);
          end
        end
        got++;
      end
      if (in_valid16 && in_ready16) begin
        q.push_back(model(16, {48'd0, a16}, {48'd0, b16}, cin16, sub16));
        sent++;
      end
      @(negedge clk);
    end
    in_valid16 = 0; out_ready16 = 1;
    total++; if (got != 20) begin bad++; $display("FAIL stream_count: got %0d results want 20", got); end
  endtask

  task automatic test_reset_flight();
    int n;
    out_ready16 = 0;
    for (int k = 0; k < 3; k++) begin
      a16 = 16'h0101 + 16'(k); b16 = 16'h0202; cin16 = 0; sub16 = 0; in_valid16 = 1;
      @(negedge clk);
    end
    in_valid16 = 0;
    for (n = 0; n < 20 && !out_valid16; n++) @(negedge clk);
    total++; if (out_valid16 !== 1'b1) begin bad++; $display("FAIL flight_fill: got out_valid=%b want 1", out_valid16); end
    #2 rst = 1;
    #1;
    total++; if (out_valid16 !== 1'b0) begin bad++; $display("FAIL async_clear_valid: got %b want 0", out_valid16); end
    total++; if ({sum16, cout16, ovf16} !== 18'h0) begin bad++; $display("FAIL async_clear_data: got sum=%h cout=%b ovf=%b want 0000 0 0", sum16, cout16, ovf16); end
    #1 rst = 0;
    #1;
    total++; if (in_ready16 !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %b want 1", in_ready16); end
    out_ready16 = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++; if (out_valid16 !== 1'b0) begin bad++; $display("FAIL stale_result: got out_valid=1 sum=%h want none (cycle %0d)", sum16, c); end
    end
  endtask

  task automatic test_width4();
    logic [65:0] q [$];
    logic [65:0] e;
    logic [9:0]  v;
    int sent = 0, got = 0;
    for (int cyc = 0; cyc < 1200 && got < 1024; cyc++) begin
      v = 10'(sent);
      in_valid4 = (sent < 1024);
      a4 = v[3:0]; b4 = v[7:4]; cin4 = v[8]; sub4 = v[9];
      #1;
      if (out_valid4 && out_ready4) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL w4_extra: got unexpected result %h want none", sum4);
        end else begin
          e = q.pop_front();
          if ({ovf4, cout4, sum4} !== {e[65:64], e[3:0]}) begin
            bad++; $display("FAIL w4_result_%0d: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                            got, sum4, cout4, ovf4, e[3:0], e[64], e[65]);
          end
        end
        got++;
      end
      if (in_valid4 && in_ready4) begin
        q.push_back(model(4, {60'd0, a4}, {60'd0, b4}, cin4, sub4));
        sent++;
      end
      @(negedge clk);
    end
    in_valid4 = 0;
    total++; if (got != 1024) begin bad++; $display("FAIL w4_count: got %0d results want 1024", got); end
  endtask

  task automatic test_width64();
    logic [65:0] q [$];
    logic [65:0] e;
    int sent = 0, got = 0;
    for (int cyc = 0; cyc < 10100 && got < 10000; cyc++) begin
      in_valid64 = (sent < 10000);
      a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
      cin64 = 1'($urandom); sub64 = 1'($urandom);
      if (cyc % 7 == 0) b64 = a64;
      #1;
      if (out_valid64 && out_ready64) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL w64_extra: got unexpected result %h want none", sum64);
        end else begin
          e = q.pop_front();
          if ({ovf64, cout64, sum64} !== e) begin
            bad++; $display("FAIL w64_result_%0d: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                            got, sum64, cout64, ovf64, e[63:0], e[64], e[65]);
          end
        end
        got++;
      end
      if (in_valid64 && in_ready64) begin
        q.push_back(model(64, a64, b64, cin64, sub64));
        sent++;
      end
      @(negedge clk);
    end
    in_valid64 = 0;
    total++; if (got != 10000) begin bad++; $display("FAIL w64_count: got %0d results want 10000", got); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_overflow();
    test_sub_cin();
    test_back_to_back();
    test_reset_flight();
    test_width4();
    test_width64();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
